// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared router constants and slot-allocator state encoding.
//  Revision : 1.0
// ============================================================================
package router_pkg;

    localparam int SLOT_PTR_SZ = 2;
    localparam int SLOT_DEPTH  = 4;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick of the first request at/after rr_ptr.
//  Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

    always_comb begin
        logic found;
        int   k;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                gnt_id = ID_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/slot_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : slot_alloc_ctrl
//  Purpose  : Circular free-list allocator with round-robin grant arbitration.
//  Revision : 1.0
// ============================================================================
module slot_alloc_ctrl
    import router_pkg::*;
#(
    parameter int DEPTH  = SLOT_DEPTH,
    parameter int PTR_SZ = SLOT_PTR_SZ,
    parameter int NREQ   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   alloc_req,
    output logic [NREQ-1:0]   alloc_gnt,
    output logic [PTR_SZ-1:0] alloc_idx,
    input  logic              rel_valid,
    input  logic [PTR_SZ-1:0] rel_idx,
    output logic [PTR_SZ:0]   free_cnt,
    output logic              init_done,
    output logic              err_overflow
);

    localparam int                c_id_w     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_SZ-1:0] c_last_ptr = PTR_SZ'(DEPTH - 1);
    localparam logic [PTR_SZ:0]   c_full     = (PTR_SZ + 1)'(DEPTH);
    localparam logic [PTR_SZ:0]   c_one      = (PTR_SZ + 1)'(1);
    localparam logic [c_id_w-1:0] c_last_req = c_id_w'(NREQ - 1);

    state_t              r_state;
    logic [PTR_SZ-1:0]   r_rd_ptr;
    logic [PTR_SZ-1:0]   r_wr_ptr;
    logic [c_id_w-1:0]   r_rr_ptr;
    logic [PTR_SZ-1:0]   r_mem [DEPTH];

    logic [NREQ-1:0]     w_arb_gnt;
    logic [c_id_w-1:0]   w_arb_id;
    logic                w_grant_ok;
    logic                w_rel_ok;
    logic                w_mem_we;
    logic [PTR_SZ-1:0]   w_mem_wdata;
    logic [PTR_SZ:0]     w_cnt_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (c_id_w)
    ) u_arb (
        .req    (alloc_req),
        .rr_ptr (r_rr_ptr),
        .gnt    (w_arb_gnt),
        .gnt_id (w_arb_id)
    );

    // Both decisions use the pre-update count, so a release into a full list
    // overflows even when a grant frees an entry on the same edge.
    assign w_grant_ok = (r_state == ST_RUN) && (free_cnt != '0) && (|alloc_req);
    assign w_rel_ok   = (r_state == ST_RUN) && rel_valid && (free_cnt != c_full);

    assign w_mem_we    = (r_state == ST_INIT) || w_rel_ok;
    assign w_mem_wdata = (r_state == ST_INIT) ? r_wr_ptr : rel_idx;

    always_comb begin
        w_cnt_next = free_cnt;
        case ({w_grant_ok, w_rel_ok})
            2'b10:   w_cnt_next = free_cnt - c_one;
            2'b01:   w_cnt_next = free_cnt + c_one;
            default: w_cnt_next = free_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_rr_ptr     <= '0;
            alloc_gnt    <= '0;
            alloc_idx    <= '0;
            free_cnt     <= '0;
            init_done    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    free_cnt <= free_cnt + c_one;
                    if (r_wr_ptr == c_last_ptr) begin
                        r_state   <= ST_RUN;
                        init_done <= 1'b1;
                        r_wr_ptr  <= '0;
                    end else begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    alloc_gnt <= w_grant_ok ? w_arb_gnt : '0;
                    if (w_grant_ok) begin
                        alloc_idx <= r_mem[r_rd_ptr];
                        r_rd_ptr  <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
                        r_rr_ptr  <= (w_arb_id == c_last_req) ? '0 : w_arb_id + 1'b1;
                    end
                    if (w_rel_ok) begin
                        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (rel_valid && !w_rel_ok) begin
                        err_overflow <= 1'b1;
                    end
                    free_cnt <= w_cnt_next;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire
